// File: rtl/mem_rd_ctrl_if.sv
// Read-initiator bus bundle: CPU-side request/return signals plus the memory read handshake.
// master = the read controller, slave = the requester/memory environment.
interface mem_rd_ctrl_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          busy;
    logic [DW-1:0] rd_data;
    logic          rd_ld;
    logic          rd_err;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ack;
    logic [DW-1:0] mem_din;

    modport master (
        input  rd_req, rd_addr, mem_ack, mem_din,
        output busy, rd_data, rd_ld, rd_err, mem_addr, mem_rd
    );

    modport slave (
        output rd_req, rd_addr, mem_ack, mem_din,
        input  busy, rd_data, rd_ld, rd_err, mem_addr, mem_rd
    );
endinterface

// File: rtl/mem_rd_ctrl.sv
// Multicycle-CPU memory read initiator with ack timeout; all outputs registered.
// Optional feature: define ALIGN_CHK_EN to reject word-misaligned addresses without a memory access.
module mem_rd_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_rd_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [DW-1:0] ERR_WORD = {DW{1'b1}};

    state_t        state_r, state_s;
    logic [7:0]    cnt_r, cnt_s;
    logic [AW-1:0] mem_addr_r, mem_addr_s;
    logic          mem_rd_r, mem_rd_s;
    logic          busy_r, busy_s;
    logic [DW-1:0] rd_data_r, rd_data_s;
    logic          rd_ld_r, rd_ld_s;
    logic          rd_err_r, rd_err_s;
    logic          take_s;

    // The DONE exit edge also samples rd_req, so zero-wait reads repeat every two cycles.
    assign take_s = bus.rd_req && ((state_r == IDLE) || (state_r == DONE));

    // Next-state and next-output computation.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        mem_addr_s = mem_addr_r;
        mem_rd_s   = mem_rd_r;
        busy_s     = busy_r;
        rd_data_s  = rd_data_r;
        rd_ld_s    = rd_ld_r;
        rd_err_s   = rd_err_r;

        case (state_r)
            IDLE: begin
                mem_rd_s = 1'b0;
                busy_s   = 1'b0;
                rd_ld_s  = 1'b0;
                rd_err_s = 1'b0;
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    rd_data_s = bus.mem_din;
                    rd_err_s  = 1'b0;
                    rd_ld_s   = 1'b1;
                    mem_rd_s  = 1'b0;
                    state_s   = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    rd_data_s = ERR_WORD;
                    rd_err_s  = 1'b1;
                    rd_ld_s   = 1'b1;
                    mem_rd_s  = 1'b0;
                    state_s   = DONE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            DONE: begin
                rd_ld_s  = 1'b0;
                rd_err_s = 1'b0;
                busy_s   = 1'b0;
                mem_rd_s = 1'b0;
                state_s  = IDLE;
            end
            default: begin
                mem_rd_s = 1'b0;
                busy_s   = 1'b0;
                rd_ld_s  = 1'b0;
                rd_err_s = 1'b0;
                cnt_s    = 8'd0;
                state_s  = IDLE;
            end
        endcase

        if (take_s) begin
`ifdef ALIGN_CHK_EN
            if (bus.rd_addr[1:0] != 2'b00) begin
                rd_data_s = ERR_WORD;
                rd_err_s  = 1'b1;
                rd_ld_s   = 1'b1;
                mem_rd_s  = 1'b0;
                busy_s    = 1'b1;
                cnt_s     = 8'd0;
                state_s   = DONE;
            end else begin
                mem_addr_s = bus.rd_addr;
                mem_rd_s   = 1'b1;
                busy_s     = 1'b1;
                rd_ld_s    = 1'b0;
                rd_err_s   = 1'b0;
                cnt_s      = 8'd0;
                state_s    = ISSUE;
            end
`else
            mem_addr_s = bus.rd_addr;
            mem_rd_s   = 1'b1;
            busy_s     = 1'b1;
            rd_ld_s    = 1'b0;
            rd_err_s   = 1'b0;
            cnt_s      = 8'd0;
            state_s    = ISSUE;
`endif
        end else begin
            cnt_s = cnt_s;
        end
    end

    // State, counter and output registers; async reset clears everything mid-read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 8'd0;
            mem_addr_r <= {AW{1'b0}};
            mem_rd_r   <= 1'b0;
            busy_r     <= 1'b0;
            rd_data_r  <= {DW{1'b0}};
            rd_ld_r    <= 1'b0;
            rd_err_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            mem_addr_r <= mem_addr_s;
            mem_rd_r   <= mem_rd_s;
            busy_r     <= busy_s;
            rd_data_r  <= rd_data_s;
            rd_ld_r    <= rd_ld_s;
            rd_err_r   <= rd_err_s;
        end
    end

    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_rd   = mem_rd_r;
    assign bus.busy     = busy_r;
    assign bus.rd_data  = rd_data_r;
    assign bus.rd_ld    = rd_ld_r;
    assign bus.rd_err   = rd_err_r;
endmodule

// File: tb/tb_mem_rd_ctrl.sv
// Randomized self-checking bench for mem_rd_ctrl against a transaction-level read model.
module tb_mem_rd_ctrl;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;
`ifdef ALIGN_CHK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_rd_ctrl_if #(.AW(AW), .DW(DW)) bus();

    mem_rd_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] held_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit misaligned(input logic [AW-1:0] a);
        return ALIGN && (a[1:0] != 2'b00);
    endfunction

    // One read: memory acks after w ISSUE cycles (w >= TIMEOUT means it never acks in time).
    task automatic do_read(input logic [AW-1:0] addr, input int w, input logic [DW-1:0] din,
                           input bit noise);
        int            n_rd;
        int            exp_n;
        bit            done;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        bus.rd_req  = 1'b1;
        bus.rd_addr = addr;
        bus.mem_ack = 1'b0;
        tick();
        bus.rd_req = 1'b0;
        if (misaligned(addr)) begin
            check("mis_mem_rd", bus.mem_rd, 1'b0);
            check("mis_rd_ld", bus.rd_ld, 1'b1);
            check("mis_rd_err", bus.rd_err, 1'b1);
            check("mis_rd_data", bus.rd_data, {DW{1'b1}});
            check("mis_busy", bus.busy, 1'b1);
            held_data = {DW{1'b1}};
            tick();
            check("mis_busy_end", bus.busy, 1'b0);
            check("mis_ld_end", bus.rd_ld, 1'b0);
            check("mis_mem_rd_end", bus.mem_rd, 1'b0);
            return;
        end
        check("acc_mem_rd", bus.mem_rd, 1'b1);
        check("acc_busy", bus.busy, 1'b1);
        check("acc_addr", bus.mem_addr, addr);
        n_rd = 1;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            bus.mem_ack = (k == w);
            bus.mem_din = (k == w) ? din : DW'($urandom);
            if (noise) begin
                bus.rd_req  = 1'($urandom_range(0, 1));
                bus.rd_addr = AW'($urandom);
            end
            tick();
            if (bus.rd_ld) begin
                done = 1'b1;
            end else begin
                n_rd++;
                check("iss_mem_rd", bus.mem_rd, 1'b1);
                check("iss_addr_hold", bus.mem_addr, addr);
            end
        end
        bus.rd_req  = 1'b0;
        bus.mem_ack = 1'($urandom_range(0, 1));
        check("ld_seen", done, 1'b1);
        if (w < TIMEOUT) begin
            exp_n    = w + 1;
            exp_data = din;
            exp_err  = 1'b0;
        end else begin
            exp_n    = TIMEOUT;
            exp_data = {DW{1'b1}};
            exp_err  = 1'b1;
        end
        held_data = exp_data;
        check("mem_rd_cycles", n_rd, exp_n);
        check("rd_data", bus.rd_data, exp_data);
        check("rd_err", bus.rd_err, exp_err);
        check("done_mem_rd", bus.mem_rd, 1'b0);
        check("done_busy", bus.busy, 1'b1);
        tick();
        bus.mem_ack = 1'b0;
        check("ld_one_cycle", bus.rd_ld, 1'b0);
        check("err_cleared", bus.rd_err, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
        check("data_held", bus.rd_data, held_data);
        check("addr_held", bus.mem_addr, addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            pulses;
        int            gap;
        bit            seen;
        logic [DW-1:0] din_v;
        logic [AW-1:0] a;
        rst         = 1'b1;
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_din = '0;
        held_data   = '0;
        repeat (3) tick();
        check("rst_busy", bus.busy, 1'b0);
        check("rst_mem_rd", bus.mem_rd, 1'b0);
        check("rst_rd_ld", bus.rd_ld, 1'b0);
        check("rst_rd_err", bus.rd_err, 1'b0);
        check("rst_rd_data", bus.rd_data, '0);
        check("rst_mem_addr", bus.mem_addr, '0);
        rst = 1'b0;
        tick();

        // Directed corner cases.
        do_read(32'h0000_0100, 0, 32'hDEAD_BEEF, 1'b0);
        do_read(32'h0000_0200, 3, 32'h1234_5678, 1'b0);
        do_read(32'h0000_0300, TIMEOUT - 1, 32'hCAFE_F00D, 1'b0);
        do_read(32'h0000_0304, TIMEOUT, 32'h0BAD_0BAD, 1'b0);
        do_read(32'h0000_0308, 100000, 32'h5555_AAAA, 1'b0);
        do_read(32'h0000_0102, 0, 32'hA5A5_A5A5, 1'b0);
        do_read(32'h0000_0104, 0, 32'h0F0F_0F0F, 1'b0);

        // rd_req held high with a zero-wait memory: one completion every two cycles.
        pulses      = 0;
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h0000_0400;
        bus.mem_ack = 1'b1;
        din_v       = '0;
        for (int i = 0; i < 20; i++) begin
            din_v       = DW'($urandom);
            bus.mem_din = din_v;
            tick();
            if (bus.rd_ld) begin
                pulses++;
                check("b2b_data", bus.rd_data, din_v);
            end
        end
        check("b2b_pulses", pulses, 10);
        bus.rd_req  = 1'b0;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 10 && bus.busy; i++) tick();
        check("b2b_drain", bus.busy, 1'b0);

        // Async reset in the middle of an ISSUE phase.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 32'h0000_0500;
        tick();
        bus.rd_req = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_rd", bus.mem_rd, 1'b0);
        check("arst_busy", bus.busy, 1'b0);
        check("arst_rd_ld", bus.rd_ld, 1'b0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        held_data = '0;
        seen      = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            bus.mem_din = DW'($urandom);
            tick();
            if (bus.rd_ld || bus.mem_rd || bus.busy) seen = 1'b1;
        end
        bus.mem_ack = 1'b0;
        check("no_stale_ld", seen, 1'b0);
        check("arst_data", bus.rd_data, '0);

        // Randomized reads with wait states, timeouts, request noise and idle gaps.
        for (int i = 0; i < 40; i++) begin
            a = AW'($urandom);
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            do_read(a, int'($urandom_range(0, 20)), DW'($urandom), 1'b1);
            gap  = int'($urandom_range(0, 3));
            seen = 1'b0;
            for (int g = 0; g < gap; g++) begin
                bus.mem_ack = 1'($urandom_range(0, 1));
                tick();
                if (bus.rd_ld || bus.mem_rd) seen = 1'b1;
            end
            bus.mem_ack = 1'b0;
            check("idle_quiet", seen, 1'b0);
            check("idle_data_held", bus.rd_data, held_data);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
